// File: rtl/mux_ctrl_pkg.sv
// Shared types and helpers for the mux select sequencer.
package mux_ctrl_pkg;

  localparam int unsigned SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    CAPTURE
  } seq_state_t;

  typedef struct packed {
    logic             vld;
    logic             is_load;
    logic [SEL_W-1:0] val;
  } sel_req_t;

  function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] cur);
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, plus a stability filter when DEBOUNCE_EN is defined.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // r_cnt counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt   <= '0;
      r_level <= r_sync2;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_level;
`else
  // Stability filter is not built; DB_CYCLES has no effect here.
  if (DB_CYCLES == 0) begin : g_db_cycles_ignored
  end

  assign o_level = r_sync2;
`endif

endmodule

// File: rtl/mux_sel_sequencer.sv
// Select sequencer for the 4:1 data mux: load/button/auto-scan steps, capture, valid/ready out.
// Define DEBOUNCE_EN to filter the step button through the stability counter.
module mux_sel_sequencer
  import mux_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SCAN_DIV  = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_auto_en,
  input  logic              i_btn_step,
  input  logic              i_sel_load,
  input  logic [SEL_W-1:0]  i_sel_load_val,
  output logic [SEL_W-1:0]  o_s,
  input  logic [DATA_W-1:0] i_mux_o,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic              o_sel_of
);

  localparam int unsigned PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);

  logic               w_btn_lvl;
  logic               w_btn_rise;
  logic               w_tick;
  sel_req_t           w_req;
  sel_req_t           w_srv;
  logic               r_btn_prev;
  logic [PRESC_W-1:0] r_presc;
  sel_req_t           r_pend;
  seq_state_t         r_state;
  logic [SEL_W-1:0]   r_s;
  logic [DATA_W-1:0]  r_data;
  logic               r_valid;
  logic               r_sel_of;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_btn  (i_btn_step),
    .o_level(w_btn_lvl)
  );

  assign w_btn_rise = w_btn_lvl & ~r_btn_prev;
  assign w_tick     = i_auto_en && (r_presc == PRESC_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_btn_prev <= 1'b0;
      r_presc    <= '0;
    end else begin
      r_btn_prev <= w_btn_lvl;
      if (!i_auto_en || w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Load beats both +1 sources; button and tick collapse into one +1.
  always_comb begin
    w_req = '0;
    if (i_sel_load) begin
      w_req.vld     = 1'b1;
      w_req.is_load = 1'b1;
      w_req.val     = i_sel_load_val;
    end else if (w_btn_rise || w_tick) begin
      w_req.vld = 1'b1;
    end
  end

  // An older pending request is served first; anything arriving alongside it is dropped.
  assign w_srv = r_pend.vld ? r_pend : w_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_pend   <= '0;
      r_s      <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_sel_of <= 1'b0;
    end else begin
      r_sel_of <= 1'b0;
      if (r_valid && i_data_ready) begin
        r_valid <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          if (w_srv.vld) begin
            if (w_srv.is_load) begin
              r_s <= w_srv.val;
            end else begin
              r_s      <= sel_next(r_s);
              r_sel_of <= (r_s == SEL_MAX);
            end
            r_pend  <= '0;
            r_state <= UPDATE;
          end
        end
        UPDATE: begin
          if (w_req.vld && !r_pend.vld) begin
            r_pend <= w_req;
          end
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          if (w_req.vld && !r_pend.vld) begin
            r_pend <= w_req;
          end
          // Overwrites an unaccepted word: the newest select always wins.
          r_data  <= i_mux_o;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_s          = r_s;
  assign o_data_out   = r_data;
  assign o_data_valid = r_valid;
  assign o_sel_of     = r_sel_of;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: cycle model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_mux_sel_sequencer;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned DB_CYCLES = 4;
  localparam logic [31:0] STEP_WORD = 32'h1111_1111;
`ifdef DEBOUNCE_EN
  localparam int PRESS   = DB_CYCLES + 1;
  localparam int BTN_LAT = DB_CYCLES + 2;
`else
  localparam int PRESS   = 1;
  localparam int BTN_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        auto_en = 1'b0;
  logic        btn = 1'b0;
  logic        sel_load = 1'b0;
  logic [1:0]  load_val = 2'd0;
  logic [1:0]  s;
  logic [31:0] mux_o;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready = 1'b1;
  logic        sel_of;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mux_o = 32'(s) * STEP_WORD;

  mux_sel_sequencer #(
    .DATA_W   (DATA_W),
    .SCAN_DIV (SCAN_DIV),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_auto_en     (auto_en),
    .i_btn_step    (btn),
    .i_sel_load    (sel_load),
    .i_sel_load_val(load_val),
    .o_s           (s),
    .i_mux_o       (mux_o),
    .o_data_out    (data_out),
    .o_data_valid  (data_valid),
    .i_data_ready  (data_ready),
    .o_sel_of      (sel_of)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: button history, scan counter, a busy countdown and a 1-deep request slot.
  int          m_s;
  logic [31:0] m_data;
  bit          m_valid;
  bit          m_of;
  bit          hist[16];
  bit          dl;
  bit          dl_old;
  int          presc;
  int          busy;
  bit          pend_v;
  bit          pend_load;
  int          pend_val;

  always @(posedge clk or negedge rst_n) begin
    bit btn_req, tick, rq_v, sv_v, sv_load, new_dl, all_diff;
    int sv_val;
    if (!rst_n) begin
      m_s = 0; m_data = '0; m_valid = 0; m_of = 0;
      for (int i = 0; i < 16; i++) hist[i] = 0;
      dl = 0; dl_old = 0; presc = 0; busy = 0;
      pend_v = 0; pend_load = 0; pend_val = 0;
    end else begin
      btn_req = dl && !dl_old;
`ifdef DEBOUNCE_EN
      all_diff = 1;
      for (int i = 1; i <= int'(DB_CYCLES); i++) if (hist[i] == dl) all_diff = 0;
      new_dl = all_diff ? hist[1] : dl;
`else
      all_diff = 0;
      new_dl = hist[0];
`endif
      dl_old = dl;
      dl = new_dl;
      for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = btn;
      tick = auto_en && (presc == int'(SCAN_DIV) - 1);
      presc = (!auto_en || tick) ? 0 : presc + 1;
      rq_v = sel_load || btn_req || tick;
      m_of = 0;
      if (m_valid && data_ready) m_valid = 0;
      if (busy == 0) begin
        sv_v    = pend_v || rq_v;
        sv_load = pend_v ? pend_load : sel_load;
        sv_val  = pend_v ? pend_val : int'(load_val);
        if (sv_v) begin
          if (sv_load) m_s = sv_val;
          else begin
            m_of = (m_s == 3);
            m_s  = (m_s + 1) % 4;
          end
          pend_v = 0;
          busy = 2;
        end
      end else begin
        if (rq_v && !pend_v) begin
          pend_v = 1; pend_load = sel_load; pend_val = int'(load_val);
        end
        if (busy == 1) begin
          m_data  = 32'(m_s) * STEP_WORD;
          m_valid = 1;
        end
        busy--;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("s", 32'(s), 32'(m_s));
      check("data_out", data_out, m_data);
      check("data_valid", 32'(data_valid), 32'(m_valid));
      check("sel_of", 32'(sel_of), 32'(m_of));
    end
  end

  task automatic press_and_wait(input int gap);
    @(negedge clk);
    btn = 1'b1;
    repeat (PRESS) @(negedge clk);
    btn = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic load_sel(input logic [1:0] v);
    @(negedge clk);
    sel_load = 1'b1;
    load_val = v;
    @(negedge clk);
    sel_load = 1'b0;
    repeat (BTN_LAT + 6) @(negedge clk);
  endtask

  initial begin
    int of_cnt;
    repeat (3) @(negedge clk);
    check("rst_s", 32'(s), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_of", 32'(sel_of), 32'd0);
    rst_n = 1'b1;

    // Manual step with exact latency from the first high sample of the button.
    @(negedge clk);
    btn = 1'b1;
    for (int i = 1; i <= BTN_LAT + 1; i++) begin
      @(negedge clk);
      if (i == PRESS) btn = 1'b0;
    end
    check("step_s", 32'(s), 32'd1);
    repeat (2) @(negedge clk);
    check("step_valid", 32'(data_valid), 32'd1);
    check("step_data", data_out, 32'h1111_1111);
    repeat (BTN_LAT + 6) @(negedge clk);

    // Wrap: four steps from 0, one overflow pulse.
    load_sel(2'd0);
    of_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      btn = 1'b1;
      for (int i = 1; i <= PRESS + BTN_LAT + 6; i++) begin
        @(negedge clk);
        if (i == PRESS) btn = 1'b0;
        of_cnt += int'(sel_of);
      end
    end
    check("wrap_s", 32'(s), 32'd0);
    check("wrap_of_count", 32'(of_cnt), 32'd1);

    // Auto-scan with consumer stalled: ticks 7/15/23/31 cycles after enable.
    data_ready = 1'b0;
    @(negedge clk);
    auto_en = 1'b1;
    repeat (32) @(negedge clk);
    check("auto_s", 32'(s), 32'd0);
    check("auto_valid", 32'(data_valid), 32'd1);
    check("auto_data", data_out, 32'h3333_3333);
    repeat (5) @(negedge clk);
    auto_en = 1'b0;
    @(negedge clk);
    auto_en = 1'b1;
    data_ready = 1'b1;
    repeat (20) @(negedge clk);
    auto_en = 1'b0;
    repeat (BTN_LAT + 8) @(negedge clk);

    // Collision: load and button request land on the same edge; only the load applies.
    for (int i = 0; i <= BTN_LAT + 8; i++) begin
      @(negedge clk);
      if (i == BTN_LAT + 1) check("coll_s", 32'(s), 32'd2);
      btn      = (i < PRESS);
      sel_load = (i == BTN_LAT);
      load_val = 2'd2;
    end
    check("coll_hold", 32'(s), 32'd2);
    repeat (BTN_LAT + 6) @(negedge clk);

    // Button during UPDATE goes pending; a load during CAPTURE is dropped.
    for (int i = 0; i <= BTN_LAT + 8; i++) begin
      @(negedge clk);
      if (i == BTN_LAT) check("pend_load_s", 32'(s), 32'd2);
      if (i == BTN_LAT + 3) check("pend_s", 32'(s), 32'd3);
      if (i == BTN_LAT + 5) begin
        check("pend_valid", 32'(data_valid), 32'd1);
        check("pend_data", data_out, 32'h3333_3333);
      end
      btn      = (i < PRESS);
      sel_load = (i == BTN_LAT - 1) || (i == BTN_LAT + 1);
      load_val = (i == BTN_LAT - 1) ? 2'd2 : 2'd0;
    end
    check("pend_final", 32'(s), 32'd3);
    repeat (6) @(negedge clk);

`ifdef DEBOUNCE_EN
    // A short glitch is filtered; a long press steps exactly once.
    load_sel(2'd0);
    @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (14) @(negedge clk);
    check("glitch_s", 32'(s), 32'd0);
    @(negedge clk);
    btn = 1'b1;
    repeat (5) @(negedge clk);
    btn = 1'b0;
    repeat (14) @(negedge clk);
    check("press_s", 32'(s), 32'd1);
`endif

    // Asynchronous reset during CAPTURE: cleared at once, nothing captured afterwards.
    @(negedge clk);
    sel_load = 1'b1;
    load_val = 2'd3;
    @(negedge clk);
    sel_load = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_s", 32'(s), 32'd0);
    check("abort_valid", 32'(data_valid), 32'd0);
    check("abort_data", data_out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_abort_valid", 32'(data_valid), 32'd0);
    check("post_abort_s", 32'(s), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
